// File: rtl/axi_read_slave_port.sv
// AXI3 slave read responder: accepts one AR burst at a time, walks FIXED/INCR/WRAP
// beat addresses into a synchronous memory and returns R beats through a 2-entry buffer.
module axi_read_slave_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_AW     = 7
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    output logic                  mem_re,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [BUS_WIDTH-1:0]  RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] B_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int MAX_SIZE = $clog2(BUS_WIDTH / 8);

    logic [0:0]            r_state;
    logic                  r_arready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [4:0]            r_beats_issued;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic [BUS_WIDTH-1:0]  r_fifo_data [2];
    logic [1:0]            r_fifo_resp [2];
    logic                  r_fifo_last [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_ar_hs;
    logic                  w_req_err;
    logic                  w_pop;
    logic                  w_more;
    logic [2:0]            w_occupancy;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_mem_issue;
    logic                  w_issue_last;
    logic                  w_push;
    logic [BUS_WIDTH-1:0]  w_push_data;
    logic [1:0]            w_push_resp;
    logic                  w_push_last;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_boundary;
    logic [ADDR_WIDTH-1:0] w_lower;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    assign w_ar_hs   = ARVALID && r_arready;
    assign w_req_err = (ARBURST == B_RSVD) || (ARSIZE > 3'(MAX_SIZE)) ||
                       ((ARBURST == B_WRAP) && !((ARLEN == 4'd1) || (ARLEN == 4'd3) ||
                                                 (ARLEN == 4'd7) || (ARLEN == 4'd15)));

    assign RVALID = (r_count != 2'd0);
    assign w_pop  = RVALID && RREADY;

    // A pop in the same cycle frees a slot, so issue may continue back-to-back.
    assign w_occupancy  = 3'(r_count) + 3'(r_inflight);
    assign w_room       = (w_occupancy < 3'd2) || w_pop;
    assign w_more       = (r_beats_issued <= {1'b0, r_len});
    assign w_issue      = (r_state == S_BURST) && w_more && w_room;
    assign w_mem_issue  = w_issue && !r_err;
    assign w_issue_last = (r_beats_issued == {1'b0, r_len});

    assign mem_re   = w_mem_issue;
    assign mem_addr = r_addr[MEM_AW-1:0];

    // Error beats bypass the memory and enter the buffer on their issue edge.
    assign w_push      = r_inflight || (w_issue && r_err);
    assign w_push_data = r_inflight ? mem_rdata : '0;
    assign w_push_resp = r_inflight ? RESP_OKAY : RESP_SLVERR;
    assign w_push_last = r_inflight ? r_inflight_last : w_issue_last;

    assign w_step     = ADDR_WIDTH'(1) << r_size;
    assign w_boundary = ADDR_WIDTH'({1'b0, r_len} + 5'd1) << r_size;
    assign w_lower    = r_addr & ~(w_boundary - ADDR_WIDTH'(1));
    assign w_incr     = r_addr + w_step;

    // NOTE: default assignment first so every path drives w_next_addr and no latch is inferred.
    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            B_INCR:  w_next_addr = w_incr;
            B_WRAP:  w_next_addr = (w_incr == (w_lower + w_boundary)) ? w_lower : w_incr;
            B_FIXED: w_next_addr = r_addr;
            default: w_next_addr = r_addr;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state         <= S_IDLE;
            r_arready       <= 1'b0;
            r_id            <= '0;
            r_addr          <= '0;
            r_len           <= '0;
            r_size          <= '0;
            r_burst         <= '0;
            r_err           <= 1'b0;
            r_beats_issued  <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight <= w_mem_issue;
            if (w_mem_issue) begin
                r_inflight_last <= w_issue_last;
            end
            case (r_state)
                S_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_state        <= S_BURST;
                        r_arready      <= 1'b0;
                        r_id           <= ARID;
                        r_addr         <= ARADDR;
                        r_len          <= ARLEN;
                        r_size         <= ARSIZE;
                        r_burst        <= ARBURST;
                        r_err          <= w_req_err;
                        r_beats_issued <= '0;
                    end
                end
                default: begin
                    if (w_issue) begin
                        r_addr         <= w_next_addr;
                        r_beats_issued <= r_beats_issued + 5'd1;
                    end
                    if (w_pop && RLAST) begin
                        r_state   <= S_IDLE;
                        r_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: the two buffer entries are reset because their head drives R outputs that must read 0 out of reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_resp[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= w_push_data;
                r_fifo_resp[r_wptr] <= w_push_resp;
                r_fifo_last[r_wptr] <= w_push_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ARREADY = r_arready;
    assign RID     = r_id;
    assign RDATA   = r_fifo_data[r_rptr];
    assign RRESP   = r_fifo_resp[r_rptr];
    assign RLAST   = r_fifo_last[r_rptr];

endmodule

// File: tb/tb_axi_read_slave_port.sv
// Directed bench for axi_read_slave_port: memory model returns 0xD0000000 | mem_addr,
// monitors log mem_re addresses, AR accepts and R handshakes at the falling edge.
module tb_axi_read_slave_port;

    localparam int AW  = 32;
    localparam int BW  = 32;
    localparam int IW  = 1;
    localparam int MAW = 7;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic           ARVALID;
    logic           ARREADY;
    logic [IW-1:0]  ARID;
    logic [AW-1:0]  ARADDR;
    logic [3:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           mem_re;
    logic [MAW-1:0] mem_addr;
    logic [BW-1:0]  mem_rdata = '0;
    logic           RVALID;
    logic           RREADY;
    logic [IW-1:0]  RID;
    logic [BW-1:0]  RDATA;
    logic [1:0]     RRESP;
    logic           RLAST;

    typedef struct {
        logic [IW-1:0] id;
        logic [BW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t          q_beat [$];
    logic [MAW-1:0] q_addr [$];
    int             q_acc  [$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    axi_read_slave_port #(
        .ADDR_WIDTH(AW),
        .BUS_WIDTH (BW),
        .ID_WIDTH  (IW),
        .MEM_AW    (MAW)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .ARID     (ARID),
        .ARADDR   (ARADDR),
        .ARLEN    (ARLEN),
        .ARSIZE   (ARSIZE),
        .ARBURST  (ARBURST),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RID      (RID),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RLAST    (RLAST)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= 32'hD000_0000 | 32'(mem_addr);
    end

    always @(negedge clk) begin
        if (mem_re) q_addr.push_back(mem_addr);
        if (ARVALID && ARREADY) q_acc.push_back(cyc + 1);
        if (RVALID && RREADY) q_beat.push_back('{RID, RDATA, RRESP, RLAST, cyc});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_beat.delete();
        q_addr.delete();
        q_acc.delete();
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int e0);
        int n0;
        n0 = q_acc.size();
        @(posedge clk);
        #1;
        ARVALID = 1'b1;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        for (int i = 0; i < 50 && q_acc.size() == n0; i++) @(posedge clk);
        #1;
        ARVALID = 1'b0;
        check("ar accepted", q_acc.size(), n0 + 1);
        e0 = (q_acc.size() > n0) ? q_acc[n0] : -100;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 300 && q_beat.size() < n; i++) @(posedge clk);
        #1;
        check($sformatf("%s beat count", tag), q_beat.size(), n);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] ea [4],
                               input logic [IW-1:0] eid, input bit err);
        check($sformatf("%s mem_re count", tag), q_addr.size(), err ? 0 : n);
        for (int i = 0; i < n; i++) begin
            if (!err && i < q_addr.size())
                check($sformatf("%s mem_addr%0d", tag, i), q_addr[i], ea[i][MAW-1:0]);
            if (i < q_beat.size()) begin
                check($sformatf("%s rdata%0d", tag, i), q_beat[i].data,
                      err ? 32'h0 : (32'hD000_0000 | ea[i]));
                check($sformatf("%s rresp%0d", tag, i), q_beat[i].resp, err ? 2'b10 : 2'b00);
                check($sformatf("%s rlast%0d", tag, i), q_beat[i].last, (i == n - 1));
                check($sformatf("%s rid%0d", tag, i), q_beat[i].id, eid);
            end
        end
    endtask

    initial begin
        int          e0;
        int          guard;
        logic [31:0] ea [4];

        ARVALID = 1'b0;
        ARID    = '0;
        ARADDR  = '0;
        ARLEN   = '0;
        ARSIZE  = '0;
        ARBURST = '0;
        RREADY  = 1'b1;

        // Reset values while clr is held low
        repeat (3) @(posedge clk);
        #1;
        check("rst arready", ARREADY, 1'b0);
        check("rst rvalid", RVALID, 1'b0);
        check("rst mem_re", mem_re, 1'b0);
        check("rst mem_addr", mem_addr, 7'h0);
        check("rst rid", RID, 1'b0);
        check("rst rdata", RDATA, 32'h0);
        check("rst rresp", RRESP, 2'b00);
        check("rst rlast", RLAST, 1'b0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        check("arready after release", ARREADY, 1'b1);

        // INCR 0x08, 3 beats, sustained RREADY: no bubbles, 2-cycle latency
        clear_q();
        send_ar(1'b1, 32'h08, 4'd2, 3'd2, 2'b01, e0);
        wait_beats("incr", 3);
        check("incr arready after rlast", ARREADY, 1'b1);
        ea = '{32'h08, 32'h0C, 32'h10, 32'h0};
        check_beats("incr", 3, ea, 1'b1, 1'b0);
        if (q_beat.size() == 3) begin
            check("incr beat0 cycle", q_beat[0].cyc, e0 + 2);
            check("incr beat1 cycle", q_beat[1].cyc, e0 + 3);
            check("incr beat2 cycle", q_beat[2].cyc, e0 + 4);
        end

        // WRAP 0x1C, 4 beats of 4 bytes: wraps at the 16-byte boundary
        clear_q();
        send_ar(1'b0, 32'h1C, 4'd3, 3'd2, 2'b10, e0);
        wait_beats("wrap", 4);
        ea = '{32'h1C, 32'h10, 32'h14, 32'h18};
        check_beats("wrap", 4, ea, 1'b0, 1'b0);

        // FIXED 0x0A, 4 beats at the same address
        clear_q();
        send_ar(1'b1, 32'h0A, 4'd3, 3'd2, 2'b00, e0);
        wait_beats("fixed", 4);
        ea = '{32'h0A, 32'h0A, 32'h0A, 32'h0A};
        check_beats("fixed", 4, ea, 1'b1, 1'b0);

        // Backpressure: RREADY low for three cycles once data is available
        clear_q();
        RREADY = 1'b0;
        send_ar(1'b0, 32'h00, 4'd3, 3'd2, 2'b01, e0);
        guard = 0;
        @(negedge clk);
        while (!RVALID && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp rvalid seen", RVALID, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp hold rvalid%0d", i), RVALID, 1'b1);
            check($sformatf("bp hold rdata%0d", i), RDATA, 32'hD000_0000);
            check($sformatf("bp hold rlast%0d", i), RLAST, 1'b0);
            check($sformatf("bp mem_re bound%0d", i), (q_addr.size() <= 2), 1'b1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        RREADY = 1'b1;
        wait_beats("bp", 4);
        ea = '{32'h00, 32'h04, 32'h08, 32'h0C};
        check_beats("bp", 4, ea, 1'b0, 1'b0);

        // Reserved burst type: SLVERR beats, no memory reads, first beat after E1
        clear_q();
        send_ar(1'b1, 32'h04, 4'd1, 3'd2, 2'b11, e0);
        wait_beats("err burst", 2);
        ea = '{32'h0, 32'h0, 32'h0, 32'h0};
        check_beats("err burst", 2, ea, 1'b1, 1'b1);
        if (q_beat.size() == 2) begin
            check("err beat0 cycle", q_beat[0].cyc, e0 + 1);
            check("err beat1 cycle", q_beat[1].cyc, e0 + 2);
        end

        // Oversized beat (8 bytes on a 4-byte bus)
        clear_q();
        send_ar(1'b0, 32'h10, 4'd1, 3'd3, 2'b01, e0);
        wait_beats("err size", 2);
        check_beats("err size", 2, ea, 1'b0, 1'b1);

        // WRAP with an illegal length
        clear_q();
        send_ar(1'b1, 32'h10, 4'd2, 3'd2, 2'b10, e0);
        wait_beats("err wraplen", 3);
        check_beats("err wraplen", 3, ea, 1'b1, 1'b1);

        // ARVALID held through a burst: second request waits for the RLAST handshake
        clear_q();
        @(posedge clk);
        #1;
        ARVALID = 1'b1;
        ARID    = 1'b0;
        ARADDR  = 32'h20;
        ARLEN   = 4'd1;
        ARSIZE  = 3'd2;
        ARBURST = 2'b01;
        for (int i = 0; i < 50 && q_acc.size() < 1; i++) @(posedge clk);
        #1;
        ARID   = 1'b1;
        ARADDR = 32'h30;
        for (int i = 0; i < 50 && q_acc.size() < 2; i++) @(posedge clk);
        #1;
        ARVALID = 1'b0;
        check("held ar accepts", q_acc.size(), 2);
        wait_beats("held", 4);
        if (q_acc.size() == 2 && q_beat.size() == 4) begin
            check("held second accept edge", q_acc[1], q_beat[1].cyc + 2);
            check("held rlast first", q_beat[1].last, 1'b1);
            check("held rdata2", q_beat[2].data, 32'hD000_0030);
            check("held rid2", q_beat[2].id, 1'b1);
            check("held rdata3", q_beat[3].data, 32'hD000_0034);
            check("held rlast3", q_beat[3].last, 1'b1);
        end

        // Reset mid-burst after the first beat
        clear_q();
        send_ar(1'b0, 32'h40, 4'd3, 3'd2, 2'b01, e0);
        for (int i = 0; i < 50 && q_beat.size() < 1; i++) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("midrst rvalid", RVALID, 1'b0);
        check("midrst mem_re", mem_re, 1'b0);
        check("midrst arready", ARREADY, 1'b0);
        check("midrst rlast", RLAST, 1'b0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        check("midrst arready after release", ARREADY, 1'b1);
        check("midrst beats kept", q_beat.size(), 1);
        if (q_beat.size() >= 1)
            check("midrst beat0 data", q_beat[0].data, 32'hD000_0040);
        clear_q();
        send_ar(1'b1, 32'h30, 4'd1, 3'd2, 2'b01, e0);
        wait_beats("post rst", 2);
        ea = '{32'h30, 32'h34, 32'h0, 32'h0};
        check_beats("post rst", 2, ea, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_slave_port.md
# axi_read_slave_port

Slave-side AXI3 read responder sitting directly downstream of the interconnect's slave read port and upstream of a synchronous single-port memory. Accepts one AR request at a time, generates FIXED/INCR/WRAP beat addresses, issues memory reads with flow control, and returns R beats with ID, response, and RLAST through a 2-entry output buffer. It replaces the bare address/memread hookup currently used between the interconnect and each memory slave.

## Interface
- ADDR_WIDTH, 32, AR address width
- BUS_WIDTH, 32, data width (bytes per beat max = BUS_WIDTH/8)
- ID_WIDTH, 1, transaction ID width
- MEM_AW, 7, memory address width; mem_addr = beat address[MEM_AW-1:0]

- clk  in  1  clock, all logic on rising edge
- clr  in  1  asynchronous active-low reset
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARID  in  ID_WIDTH  request ID
- ARADDR  in  ADDR_WIDTH  start byte address
- ARLEN  in  4  beats minus 1
- ARSIZE  in  3  log2 bytes per beat
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- mem_re  out  1  memory read strobe
- mem_addr  out  MEM_AW  memory read address
- mem_rdata  in  BUS_WIDTH  read data, valid the cycle after mem_re is sampled
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RID  out  ID_WIDTH  = latched ARID
- RDATA  out  BUS_WIDTH  beat data
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat of burst

## Operation
- States: IDLE, BURST. ARREADY = 1 only in IDLE (registered).
- IDLE: on ARVALID&ARREADY latch ID, ADDR, LEN, SIZE, BURST; beats_issued = 0, beats_sent = 0; go to BURST; ARREADY drops same edge.
- Error request: ARBURST = 11, or ARSIZE > log2(BUS_WIDTH/8), or WRAP with ARLEN not in {1,3,7,15}. Still returns ARLEN+1 beats, RRESP = 10, RDATA = 0, mem_re never asserted.
- Beat address: FIXED holds ARADDR; INCR adds 1<<SIZE, modulo 2^ADDR_WIDTH; WRAP boundary = (LEN+1)<<SIZE bytes, lower = addr & ~(boundary-1), next = addr+(1<<SIZE), if next == lower+boundary then next = lower.
- Issue: mem_re = 1 in BURST when beats_issued <= LEN and (fifo_count + inflight) < 2. inflight is 1 the cycle after a mem_re.
- Capture: inflight data pushed into 2-entry FIFO with RLAST = (beat index == LEN), RRESP = 00.
- R: RVALID = FIFO not empty; head presented on RID/RDATA/RRESP/RLAST. Pop on RVALID&RREADY.
- BURST → IDLE on the edge accepting the RLAST beat; ARREADY = 1 from that edge.
- One outstanding transaction; no AR accepted in BURST.

## Timing
- Reset (clr low, async): state IDLE, ARREADY 0, mem_re 0, mem_addr 0, RVALID 0, RID/RDATA/RRESP/RLAST 0, FIFO empty, counters 0. ARREADY goes 1 on first edge after clr deasserts.
- AR accepted at edge E0: mem_re = 1 with first address during cycle E0–E1; data captured at E2; RVALID = 1 after E2 (2-cycle latency).
- Sustained RREADY = 1: one beat per cycle, no bubbles; burst of N beats completes at E0+N+1.
- RREADY low: RVALID and all R outputs held stable; at most 2 buffered beats, issue stops (no FIFO overflow, no dropped mem_rdata).
- Push and pop same edge with FIFO full: allowed, count unchanged.
- Error burst: first RVALID after E1, one beat per cycle.
- Reset mid-burst: all in-flight data and beats discarded immediately; no RLAST emitted.

## Test plan
- INCR: ARADDR 0x08, LEN 2, SIZE 2, ID 1, RREADY = 1 → mem_addr 0x08, 0x0C, 0x10; 3 beats RID 1, RRESP 00, RLAST on beat 3 only; ARREADY high next edge.
- WRAP: ARADDR 0x1C, LEN 3, SIZE 2 → mem_addr 0x1C, 0x10, 0x14, 0x18; FIXED ARADDR 0x0A, LEN 3 → 0x0A four times.
- Backpressure: INCR LEN 3 at 0x00, RREADY low for 3 cycles after first RVALID → RDATA stable, at most 2 mem_re before first pop, all 4 beats returned in order.
- Errors: ARBURST 11, LEN 1 → 2 beats RRESP 10, RDATA 0, RLAST on beat 2, mem_re never 1; ARSIZE 3 at BUS_WIDTH 32 → same.
- ARVALID held high during BURST → second request accepted only on the edge after the first RLAST handshake.
- Reset mid-burst: clr low after beat 1 of LEN 3 → RVALID, mem_re, ARREADY 0 immediately; after release ARREADY 1 and a new request completes normally.
